// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the cfg_regfile configuration register file:
//   - RST_IMG_DEFAULT : default 16 x 8 reset image (entry 2 = 8'h81,
//                       entry 3 = 8'h20, all others 0)
//   - ADDR_*          : named addresses of the first four entries
//   - even_parity()   : parity helper used when REGFILE_PARITY_EN is defined
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DEF_DW    = 8;
   localparam int DEF_DEPTH = 16;

   // Entry i lives at bits [i*DW +: DW]; entries 15..4 are zero.
   localparam logic [DEF_DEPTH*DEF_DW-1:0] RST_IMG_DEFAULT =
      {96'h0, 8'h20, 8'h81, 16'h0000};

   // Entries 0..NEXP-1 are exported to the downstream configuration inputs.
   localparam int ADDR_CTRL       = 0;
   localparam int ADDR_UART_CFG   = 1;
   localparam int ADDR_ALU_CFG    = 2;
   localparam int ADDR_CLKDIV_CFG = 3;

   // Widest data word the parity helper covers; callers zero-extend.
   localparam int PAR_MAX_W = 64;

   // Even parity bit: the stored word plus this bit holds an even count of ones.
   function automatic logic even_parity(input logic [PAR_MAX_W-1:0] word);
      return ^word;
   endfunction

endpackage

// File: rtl/cfg_regfile_if.sv
// -----------------------------------------------------------------------------
// cfg_regfile_if
// Register-file access bus between the control FSM (master) and cfg_regfile
// (slave).
//   wr_en, rd_en      : write / read requests, sampled on the rising clock edge
//   addr    [AW-1:0]  : entry address shared by read and write
//   wr_data [DW-1:0]  : write data
//   wr_mask [DW-1:0]  : per-bit write enable
//   rd_data [DW-1:0]  : registered read data
//   rd_valid          : one-cycle pulse, rd_data valid
//   err               : one-cycle pulse, bad address or read-only write
// -----------------------------------------------------------------------------
interface cfg_regfile_if #(
   parameter int DW = 8,
   parameter int AW = 4
) ();

   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] wr_mask;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          err;

   modport master (
      output wr_en, rd_en, addr, wr_data, wr_mask,
      input  rd_data, rd_valid, err
   );

   modport slave (
      input  wr_en, rd_en, addr, wr_data, wr_mask,
      output rd_data, rd_valid, err
   );

endinterface

// File: rtl/regfile_parity.sv
// -----------------------------------------------------------------------------
// regfile_parity
// Parity generate/check for cfg_regfile (used only with REGFILE_PARITY_EN).
//   wr_word     in  DW  merged word about to be stored
//   wr_par      out 1   even parity for wr_word
//   rd_word     in  DW  word currently addressed for read
//   rd_par      in  1   parity bit stored alongside rd_word
//   rd_mismatch out 1   stored parity disagrees with rd_word
// Purely combinational.
// -----------------------------------------------------------------------------
module regfile_parity
   import regfile_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic [DW-1:0] wr_word,
   output logic          wr_par,
   input  logic [DW-1:0] rd_word,
   input  logic          rd_par,
   output logic          rd_mismatch
);

   assign wr_par      = even_parity(PAR_MAX_W'(wr_word));
   assign rd_mismatch = even_parity(PAR_MAX_W'(rd_word)) != rd_par;

endmodule

// File: rtl/cfg_regfile.sv
// -----------------------------------------------------------------------------
// cfg_regfile
// Parametrised configuration register file with per-bit write masks,
// read-only entries, read-before-write on simultaneous access, address-range
// error reporting and NEXP combinationally exported entries.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous, active-low reset
//   bus        slave         cfg_regfile_if (wr_en, rd_en, addr, wr_data,
//                            wr_mask, rd_data, rd_valid, err)
//   regs_out   out  NEXP*DW  entries 0..NEXP-1, entry i at [i*DW +: DW]
//   parity_err out  1        only with REGFILE_PARITY_EN: pulses with
//                            rd_valid when the stored parity mismatches
//
// Build option: define REGFILE_PARITY_EN to add one even-parity bit per entry.
// -----------------------------------------------------------------------------
module cfg_regfile
   import regfile_pkg::*;
#(
   parameter int                  DW      = 8,
   parameter int                  DEPTH   = 16,
   parameter int                  AW      = 4,
   parameter int                  NEXP    = 4,
   parameter logic [DEPTH*DW-1:0] RST_IMG = RST_IMG_DEFAULT,
   parameter logic [DEPTH-1:0]    RO_MASK = '0
) (
   input  logic               clk,
   input  logic               rst,
   cfg_regfile_if.slave       bus,
   output logic [NEXP*DW-1:0] regs_out
`ifdef REGFILE_PARITY_EN
   ,
   output logic               parity_err
`endif
);

   logic [DW-1:0] entry_val [DEPTH];
   logic [DW-1:0] rd_word;
   logic [DW-1:0] merged;
   logic          in_range;
   logic          ro_hit;
   logic          wr_ok;

   // DEPTH need not be a power of two, so the top of the address space may be
   // unpopulated.
   assign in_range = 32'(bus.addr) < 32'(DEPTH);

   // Addressed entry and its read-only flag. Out-of-range addresses match no
   // entry, leaving rd_word = 0 and ro_hit = 0.
   always_comb begin
      rd_word = '0;
      ro_hit  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.addr == AW'(i)) begin
            rd_word = entry_val[i];
            ro_hit  = RO_MASK[i];
         end
      end
   end

   // Only one entry is written per cycle, so the merge is computed once from
   // the addressed entry and shared by all storage slots.
   assign merged = (rd_word & ~bus.wr_mask) | (bus.wr_data & bus.wr_mask);
   assign wr_ok  = bus.wr_en & in_range & ~ro_hit;

`ifdef REGFILE_PARITY_EN
   logic entry_par [DEPTH];
   logic rd_par;
   logic wr_par;
   logic rd_mismatch;

   always_comb begin
      rd_par = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (bus.addr == AW'(i)) begin
            rd_par = entry_par[i];
         end
      end
   end

   regfile_parity #(
      .DW (DW)
   ) u_parity (
      .wr_word     (merged),
      .wr_par      (wr_par),
      .rd_word     (rd_word),
      .rd_par      (rd_par),
      .rd_mismatch (rd_mismatch)
   );
`endif

   genvar gi;

   // Storage: one register per entry. A reset image is required, so the
   // entries are flops rather than a RAM.
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [DW-1:0] q;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               q <= RST_IMG[gi*DW +: DW];
            end else if (wr_ok && (bus.addr == AW'(gi))) begin
               q <= merged;
            end
         end

         assign entry_val[gi] = q;

`ifdef REGFILE_PARITY_EN
         logic p;

         // Parity follows the merged word, so masked writes stay consistent.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               p <= even_parity(PAR_MAX_W'(RST_IMG[gi*DW +: DW]));
            end else if (wr_ok && (bus.addr == AW'(gi))) begin
               p <= wr_par;
            end
         end

         assign entry_par[gi] = p;
`endif
      end

      for (gi = 0; gi < NEXP; gi++) begin : g_export
         assign regs_out[gi*DW +: DW] = entry_val[gi];
      end
   endgenerate

   // Read port and status pulses. The read uses the pre-edge contents, so a
   // simultaneous write to the same address is seen only from the next cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rd_data  <= '0;
         bus.rd_valid <= 1'b0;
         bus.err      <= 1'b0;
`ifdef REGFILE_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else begin
         bus.rd_valid <= bus.rd_en;
         bus.err      <= (bus.rd_en & ~in_range) |
                         (bus.wr_en & (~in_range | ro_hit));
         if (bus.rd_en) begin
            bus.rd_data <= in_range ? rd_word : '0;
         end
`ifdef REGFILE_PARITY_EN
         parity_err   <= bus.rd_en & in_range & rd_mismatch;
`endif
      end
   end

endmodule

// File: tb/tb_cfg_regfile.sv
// -----------------------------------------------------------------------------
// tb_cfg_regfile
// Self-checking bench for cfg_regfile (DEPTH=12, entry 1 read-only).
// Stimulus pushes the hand-computed expected response into a queue; a monitor
// pops and compares whenever rd_valid or err is presented.
// Define REGFILE_PARITY_EN to include the parity-error case.
// -----------------------------------------------------------------------------
module tb_cfg_regfile;
   import regfile_pkg::*;

   localparam int DW    = 8;
   localparam int DEPTH = 12;
   localparam int AW    = 4;
   localparam int NEXP  = 4;
   localparam logic [DEPTH*DW-1:0] TB_IMG = RST_IMG_DEFAULT[DEPTH*DW-1:0];
   localparam logic [DEPTH-1:0]    TB_RO  = 12'h002;

   typedef struct packed {
      logic          valid;
      logic [DW-1:0] data;
      logic          err;
      logic          perr;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NEXP*DW-1:0] regs_out;
`ifdef REGFILE_PARITY_EN
   logic               parity_err;
`endif

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   cfg_regfile_if #(.DW(DW), .AW(AW)) bus ();

   cfg_regfile #(
      .DW      (DW),
      .DEPTH   (DEPTH),
      .AW      (AW),
      .NEXP    (NEXP),
      .RST_IMG (TB_IMG),
      .RO_MASK (TB_RO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .regs_out   (regs_out)
`ifdef REGFILE_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // One bus cycle: drive, record the expected response, advance one edge.
   task automatic op(input logic w, input logic r, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] m,
                     input logic [DW-1:0] xd, input logic xe, input logic xp);
      exp_t e;
      bus.wr_en   = w;
      bus.rd_en   = r;
      bus.addr    = a;
      bus.wr_data = d;
      bus.wr_mask = m;
      if (r || xe) begin
         e.valid = r;
         e.data  = xd;
         e.err   = xe;
         e.perr  = xp;
         exp_q.push_back(e);
      end
      $display("txn w=%0b r=%0b addr=%0d wdata=%02h mask=%02h exp_rd=%02h exp_err=%0b",
               w, r, a, d, m, xd, xe);
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] xd, input logic xe);
      op(1'b0, 1'b1, a, '0, '0, xd, xe, 1'b0);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] m, input logic xe);
      op(1'b1, 1'b0, a, d, m, '0, xe, 1'b0);
   endtask

   task automatic rw(input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input logic [DW-1:0] m, input logic [DW-1:0] xd, input logic xe);
      op(1'b1, 1'b1, a, d, m, xd, xe, 1'b0);
   endtask

   // Monitor: compare each presented response against the queue head.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.rd_valid || bus.err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {30'd0, bus.rd_valid, bus.err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rd_valid", 32'(bus.rd_valid), 32'(e.valid));
               check("err", 32'(bus.err), 32'(e.err));
               if (e.valid) begin
                  check("rd_data", 32'(bus.rd_data), 32'(e.data));
               end
`ifdef REGFILE_PARITY_EN
               check("parity_err", 32'(parity_err), 32'(e.perr));
`endif
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.addr    = '0;
      bus.wr_data = '0;
      bus.wr_mask = '0;

      // Reset state
      #23;
      check("rst_rd_data", 32'(bus.rd_data), 32'h0);
      check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
      check("rst_err", 32'(bus.err), 32'h0);
      check("rst_regs_out", regs_out, 32'h2081_0000);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Read every address, including the unpopulated 12..15
      for (int i = 0; i < 16; i++) begin
         rd(AW'(i), (i == ADDR_ALU_CFG) ? 8'h81 : (i == ADDR_CLKDIV_CFG) ? 8'h20 : 8'h00, i >= DEPTH);
      end

      // Masked write, then read back
      wr(4'd2, 8'hFF, 8'h0F, 1'b0);
      rd(4'd2, 8'h8F, 1'b0);
      check("regs_out_e2", 32'(regs_out[23:16]), 32'h8F);

      // Read-only entry and out-of-range write
      wr(4'(ADDR_UART_CFG), 8'hAA, 8'hFF, 1'b1);
      rd(4'(ADDR_UART_CFG), 8'h00, 1'b0);
      wr(4'd13, 8'h55, 8'hFF, 1'b1);

      // Zero mask is a legal no-op
      wr(4'd6, 8'hFF, 8'h00, 1'b0);
      rd(4'd6, 8'h00, 1'b0);

      // Simultaneous read/write: read-before-write
      rw(4'd5, 8'h3C, 8'hFF, 8'h00, 1'b0);
      rd(4'd5, 8'h3C, 1'b0);

      // Back-to-back write then read, exported entries
      wr(4'(ADDR_CTRL), 8'h5A, 8'hFF, 1'b0);
      rd(4'(ADDR_CTRL), 8'h5A, 1'b0);
      check("regs_out_e0", 32'(regs_out[7:0]), 32'h5A);
      wr(4'd3, 8'h10, 8'h30, 1'b0);
      rd(4'd3, 8'h10, 1'b0);
      check("regs_out_e3", 32'(regs_out[31:24]), 32'h10);

      // Combined: read ok + read-only write error; out-of-range read + write
      rw(4'd1, 8'h77, 8'hFF, 8'h00, 1'b1);
      rw(4'd14, 8'h77, 8'hFF, 8'h00, 1'b1);

      // Idle holds rd_data
      rd(4'd2, 8'h8F, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check("idle_rd_data", 32'(bus.rd_data), 32'h8F);
      check("idle_rd_valid", 32'(bus.rd_valid), 32'h0);
      check("regs_out_all", regs_out, 32'h108F_005A);

`ifdef REGFILE_PARITY_EN
      force dut.g_entry[4].q = 8'h01;
      #1;
      release dut.g_entry[4].q;
      op(1'b0, 1'b1, 4'd4, '0, '0, 8'h01, 1'b0, 1'b1);
      wr(4'd4, 8'h00, 8'hFF, 1'b0);
      rd(4'd4, 8'h00, 1'b0);
`endif

      // Reset asserted while a read is being presented
      exp_q.push_back('{valid: 1'b1, data: 8'h8F, err: 1'b0, perr: 1'b0});
      bus.rd_en = 1'b1;
      bus.addr  = 4'd2;
      $display("txn w=0 r=1 addr=2 exp_rd=8f then async reset");
      @(posedge clk);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rst_mid_rd_valid", 32'(bus.rd_valid), 32'h0);
      check("rst_mid_rd_data", 32'(bus.rd_data), 32'h0);
      check("rst_mid_regs_out", regs_out, 32'h2081_0000);
      @(posedge clk);
      #1;
      bus.rd_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rd(4'd2, 8'h81, 1'b0);
      rd(4'd5, 8'h00, 1'b0);
      rd(4'd0, 8'h00, 1'b0);
      rd(4'd3, 8'h20, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
